// File: rtl/retire_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : retire_trace_fifo
// Purpose  : Buffers per-instruction retirement events (PC, instruction, rd
//            write-back, store) into a DEPTH-entry FIFO drained by a
//            valid/ready consumer. Stores seen before their retire pulse are
//            held in a pending register and attached to that retirement.
//            Retirements arriving while full are dropped and counted.
// Revision : 1.0  initial release
// ============================================================================
module retire_trace_fifo #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       update_i,
    input  logic [XLEN-1:0]            pc_i,
    input  logic [XLEN-1:0]            instr_i,
    input  logic [4:0]                 reg_addr_i,
    input  logic [XLEN-1:0]            reg_data_i,
    input  logic                       mem_wrt_i,
    input  logic [XLEN-1:0]            mem_addr_i,
    input  logic [XLEN-1:0]            mem_data_i,
    output logic                       trace_valid_o,
    input  logic                       trace_ready_i,
    output logic [XLEN-1:0]            trace_pc_o,
    output logic [XLEN-1:0]            trace_instr_o,
    output logic [4:0]                 trace_rd_o,
    output logic [XLEN-1:0]            trace_rd_data_o,
    output logic                       trace_mem_wrt_o,
    output logic [XLEN-1:0]            trace_mem_addr_o,
    output logic [XLEN-1:0]            trace_mem_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [15:0]                drop_cnt_o,
    output logic [31:0]                retire_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    // Entry storage, one array per field
    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [XLEN-1:0] r_instr_mem [DEPTH];
    logic [4:0]      r_rd_mem    [DEPTH];
    logic [XLEN-1:0] r_rdd_mem   [DEPTH];
    logic            r_mw_mem    [DEPTH];
    logic [XLEN-1:0] r_ma_mem    [DEPTH];
    logic [XLEN-1:0] r_md_mem    [DEPTH];

    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [15:0]     r_drop_cnt;
    logic [31:0]     r_retire_cnt;

    logic            r_pend;
    logic [XLEN-1:0] r_pend_addr;
    logic [XLEN-1:0] r_pend_data;

    logic            w_valid;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_st_wrt;
    logic [XLEN-1:0] w_st_addr;
    logic [XLEN-1:0] w_st_data;
    logic [XLEN-1:0] w_rd_data;

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == C_DEPTH);
    assign w_pop   = w_valid && trace_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_push  = update_i && (!w_full || w_pop);
    assign w_drop  = update_i && w_full && !w_pop;

    // Same-cycle store wins over the pending one; no store means all-zero fields
    assign w_st_wrt  = mem_wrt_i || r_pend;
    assign w_st_addr = mem_wrt_i ? mem_addr_i : (r_pend ? r_pend_addr : '0);
    assign w_st_data = mem_wrt_i ? mem_data_i : (r_pend ? r_pend_data : '0);
    assign w_rd_data = (reg_addr_i == 5'd0) ? '0 : reg_data_i;

    // Entry write port; contents are only observed through valid-gated outputs
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= pc_i;
            r_instr_mem[r_wr_ptr] <= instr_i;
            r_rd_mem[r_wr_ptr]    <= reg_addr_i;
            r_rdd_mem[r_wr_ptr]   <= w_rd_data;
            r_mw_mem[r_wr_ptr]    <= w_st_wrt;
            r_ma_mem[r_wr_ptr]    <= w_st_addr;
            r_md_mem[r_wr_ptr]    <= w_st_data;
        end
    end

    // Pointers, occupancy and the drop/retire counters
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_drop_cnt   <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
            if (update_i) r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    // Pending store: a retire consumes it (a same-cycle store goes straight
    // into the retiring entry), otherwise a store loads or overwrites it
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
        end else if (update_i) begin
            r_pend      <= 1'b0;
        end else if (mem_wrt_i) begin
            r_pend      <= 1'b1;
            r_pend_addr <= mem_addr_i;
            r_pend_data <= mem_data_i;
        end
    end

    // Head entry is driven from registered state only, zeroed when empty
    assign trace_valid_o    = w_valid;
    assign trace_pc_o       = w_valid ? r_pc_mem[r_rd_ptr]    : '0;
    assign trace_instr_o    = w_valid ? r_instr_mem[r_rd_ptr] : '0;
    assign trace_rd_o       = w_valid ? r_rd_mem[r_rd_ptr]    : '0;
    assign trace_rd_data_o  = w_valid ? r_rdd_mem[r_rd_ptr]   : '0;
    assign trace_mem_wrt_o  = w_valid ? r_mw_mem[r_rd_ptr]    : 1'b0;
    assign trace_mem_addr_o = w_valid ? r_ma_mem[r_rd_ptr]    : '0;
    assign trace_mem_data_o = w_valid ? r_md_mem[r_rd_ptr]    : '0;

    assign count_o      = r_count;
    assign full_o       = w_full;
    assign empty_o      = !w_valid;
    assign drop_cnt_o   = r_drop_cnt;
    assign retire_cnt_o = r_retire_cnt;

endmodule
`default_nettype wire
